// File: rtl/muxd_arb.sv
// muxd_arb: N-channel multiplexing arbiter with a single registered output stage.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   mode_in   - 0 = directed (sel_in picks the channel), 1 = round-robin
//   sel_in    - channel to select in directed mode
//   valid_in  - per-channel data valid
//   d_in      - per-channel data, packed [N-1:0][W-1:0]
//   ready_out - per-channel accept (one-hot or zero), combinational
//   m_out     - registered output word, reads 0 while valid_out is 0
//   ch_out    - channel that sourced m_out
//   valid_out - m_out/ch_out hold a word
//   ready_in  - downstream accept
//   err_out   - one-cycle pulse after a directed cycle with sel_in >= N and any valid_in
//   count_out - number of completed output transfers (wraps)
module muxd_arb #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode_in,
    input  logic [$clog2(N)-1:0]         sel_in,
    input  logic [N-1:0]                 valid_in,
    input  logic [N-1:0][W-1:0]          d_in,
    output logic [N-1:0]                 ready_out,
    output logic [W-1:0]                 m_out,
    output logic [$clog2(N)-1:0]         ch_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         err_out,
    output logic [15:0]                  count_out
);

    localparam int          SW = $clog2(N);
    localparam int unsigned NU = N;

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic          gnt_vld;
    logic [SW-1:0] ptr_nxt;
    logic          can_accept;
    logic          accept;
    logic          out_xfer;
    logic          err_cond;

    assign can_accept = !valid_out || ready_in;
    assign accept     = !rst && can_accept && gnt_vld;
    assign out_xfer   = valid_out && ready_in;
    assign err_cond   = !mode_in && (int'(sel_in) >= N) && (|valid_in);

    // Grant selection. The round-robin search walks offsets from the far end
    // down to zero so the last hit (closest to ptr) wins.
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        if (mode_in) begin
            for (int unsigned k = NU; k > 0; k--) begin
                idx = (int'(ptr) + k - 1) % NU;
                if (valid_in[idx]) begin
                    gnt     = SW'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end else if (int'(sel_in) < N) begin
            if (valid_in[sel_in]) begin
                gnt     = sel_in;
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = SW'((int'(gnt) + 1) % NU);
    end

    always_comb begin
        ready_out = '0;
        if (accept) begin
            ready_out[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            m_out     <= '0;
            ch_out    <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            count_out <= '0;
        end else begin
            err_out <= err_cond;
            if (out_xfer) begin
                count_out <= count_out + 16'd1;
            end
            if (accept) begin
                m_out     <= d_in[gnt];
                ch_out    <= gnt;
                valid_out <= 1'b1;
                if (mode_in) begin
                    ptr <= ptr_nxt;
                end
            end else if (out_xfer) begin
                // Drained with nothing to replace it: clear data so m_out reads 0.
                valid_out <= 1'b0;
                m_out     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_muxd_arb.sv
// tb_muxd_arb: directed self-checking bench for muxd_arb (N=3, W=16).
module tb_muxd_arb;

    logic                 clk;
    logic                 rst;
    logic                 mode_in;
    logic [1:0]           sel_in;
    logic [2:0]           valid_in;
    logic [2:0][15:0]     d_in;
    logic [2:0]           ready_out;
    logic [15:0]          m_out;
    logic [1:0]           ch_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 err_out;
    logic [15:0]          count_out;

    int          checks;
    int          failures;
    logic        exp_v;
    logic [15:0] exp_cnt;

    muxd_arb #(.N(3), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_in   (mode_in),
        .sel_in    (sel_in),
        .valid_in  (valid_in),
        .d_in      (d_in),
        .ready_out (ready_out),
        .m_out     (m_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .err_out   (err_out),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; acc says whether the bench expects an input acceptance at it.
    task automatic tick(input bit acc);
        bit xfer;
        xfer = exp_v && ready_in && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_v   = 1'b0;
            exp_cnt = '0;
        end else begin
            if (xfer) exp_cnt = exp_cnt + 16'd1;
            exp_v = acc || (exp_v && !ready_in);
        end
    endtask

    initial begin
        int rr_a [5];
        int rr_b [3];
        rr_a = '{0, 1, 2, 0, 1};
        rr_b = '{2, 0, 2};
        checks   = 0;
        failures = 0;
        exp_v    = 1'b0;
        exp_cnt  = '0;

        // Reset with live inputs
        rst      = 1'b1;
        mode_in  = 1'b0;
        sel_in   = 2'd0;
        valid_in = 3'b111;
        d_in     = {16'hC2C2, 16'hBEEF, 16'hA0A0};
        ready_in = 1'b1;
        #1;
        check_eq("rst_ready", 32'(ready_out), 32'h0);
        tick(0);
        tick(0);
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        check_eq("rst_m", 32'(m_out), 32'h0);
        check_eq("rst_ch", 32'(ch_out), 32'h0);
        check_eq("rst_err", 32'(err_out), 32'h0);
        check_eq("rst_cnt", 32'(count_out), 32'h0);

        // Directed burst on channel 1
        rst    = 1'b0;
        sel_in = 2'd1;
        #1;
        check_eq("dir_ready", 32'(ready_out), 32'b010);
        tick(1);
        check_eq("dir_m", 32'(m_out), 32'hBEEF);
        check_eq("dir_ch", 32'(ch_out), 32'd1);
        check_eq("dir_valid", 32'(valid_out), 32'd1);
        check_eq("dir_cnt0", 32'(count_out), 32'd0);
        tick(1);
        check_eq("dir_cnt1", 32'(count_out), 32'd1);
        tick(1);
        check_eq("dir_cnt2", 32'(count_out), 32'd2);
        valid_in = 3'b000;
        tick(0);
        check_eq("drain_cnt", 32'(count_out), 32'd3);
        check_eq("drain_valid", 32'(valid_out), 32'd0);
        check_eq("drain_m", 32'(m_out), 32'h0);

        // Out-of-range select
        sel_in   = 2'd3;
        valid_in = 3'b001;
        #1;
        check_eq("oor_ready", 32'(ready_out), 32'h0);
        tick(0);
        check_eq("oor_err", 32'(err_out), 32'd1);
        check_eq("oor_valid", 32'(valid_out), 32'd0);
        check_eq("oor_m", 32'(m_out), 32'h0);
        valid_in = 3'b000;
        tick(0);
        check_eq("oor_err_clr", 32'(err_out), 32'd0);

        // Round-robin fairness, ptr starts at 0
        mode_in  = 1'b1;
        sel_in   = 2'd0;
        valid_in = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("rr_ready", 32'(ready_out), 32'(3'b001 << rr_a[i]));
            tick(1);
            check_eq("rr_ch", 32'(ch_out), 32'(rr_a[i]));
            check_eq("rr_m", 32'(m_out), 32'(d_in[rr_a[i]]));
        end

        // ptr=2 with only channel 0 -> grant 0, ptr becomes 1
        valid_in = 3'b001;
        #1;
        check_eq("rr_wrap_ready", 32'(ready_out), 32'b001);
        tick(1);
        check_eq("rr_wrap_ch", 32'(ch_out), 32'd0);

        // Skip: ptr=1, valid 101 -> 2, 0, 2
        valid_in = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("skip_ch", 32'(ch_out), 32'(rr_b[i]));
        end
        check_eq("skip_cnt", 32'(count_out), 32'(exp_cnt));

        // Backpressure while holding the C2C2 word from channel 2
        ready_in  = 1'b0;
        mode_in   = 1'b0;
        sel_in    = 2'd2;
        valid_in  = 3'b100;
        d_in[2]   = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_ready", 32'(ready_out), 32'h0);
            tick(0);
            check_eq("bp_m", 32'(m_out), 32'hC2C2);
            check_eq("bp_ch", 32'(ch_out), 32'd2);
            check_eq("bp_valid", 32'(valid_out), 32'd1);
            check_eq("bp_cnt", 32'(count_out), 32'(exp_cnt));
        end
        ready_in = 1'b1;
        #1;
        check_eq("bp_rel_ready", 32'(ready_out), 32'b100);
        tick(1);
        check_eq("bp_rel_m", 32'(m_out), 32'h1234);
        check_eq("bp_rel_cnt", 32'(count_out), 32'(exp_cnt));
        valid_in = 3'b000;
        tick(0);
        check_eq("bp_last_cnt", 32'(count_out), 32'(exp_cnt));
        check_eq("bp_last_valid", 32'(valid_out), 32'd0);
        tick(0);
        check_eq("bp_nodup_cnt", 32'(count_out), 32'(exp_cnt));

        // Counter wrap
        sel_in   = 2'd0;
        valid_in = 3'b001;
        tick(1);
        for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) tick(1);
        check_eq("wrap_ffff", 32'(count_out), 32'hFFFF);
        tick(1);
        check_eq("wrap_zero", 32'(count_out), 32'h0);
        check_eq("wrap_valid", 32'(valid_out), 32'd1);

        // Move ptr to 1, then reset while a word is held
        mode_in  = 1'b1;
        valid_in = 3'b111;
        tick(1);
        check_eq("pre_rst_ch", 32'(ch_out), 32'd0);
        check_eq("pre_rst_cnt", 32'(count_out), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(ready_out), 32'h0);
        tick(0);
        check_eq("post_rst_valid", 32'(valid_out), 32'd0);
        check_eq("post_rst_m", 32'(m_out), 32'h0);
        check_eq("post_rst_cnt", 32'(count_out), 32'h0);
        rst      = 1'b0;
        valid_in = 3'b011;
        #1;
        check_eq("post_rst_ptr", 32'(ready_out), 32'b001);
        tick(1);
        check_eq("post_rst_ch", 32'(ch_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
